// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for pipeline stage registers and the stage-level monitors
// that observe them.
//   occ_t : occupancy encoding reported on pipe_stage_reg.occ_o
//           OCC_EMPTY (0) / OCC_ONE (1, main valid) / OCC_FULL (2, main + skid)
// -----------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

endpackage

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Valid/ready pipeline stage register carrying one packed DATA_W payload.
// With SKID_EN=1 a second (skid) entry absorbs the one payload that slips in
// while the registered in_ready_o is still catching up with a downstream
// stall. With SKID_EN=0 it is a single entry with a combinational in_ready_o.
//
// Ports
//   clk          : clock, rising edge
//   reset_n      : asynchronous active-low reset
//   flush_i      : synchronous clear; drops held payloads and same-cycle handshakes
//   in_valid_i   : upstream payload present
//   in_ready_o   : stage can accept a payload
//   in_data_i    : upstream payload
//   out_valid_o  : main entry holds a payload
//   out_ready_i  : downstream accepts the payload
//   out_data_o   : main entry payload (keeps last value after draining)
//   occ_o        : occupancy 0..2
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int DATA_W  = 128,
    parameter int SKID_EN = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occ_o
);
    import pipe_pkg::*;

    occ_t              occ_q, occ_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q;
    logic              in_fire;
    logic              out_fire;

    assign out_valid_o = (occ_q != OCC_EMPTY);
    assign out_data_o  = main_q;
    assign occ_o       = occ_q;

    assign in_fire  = in_valid_i & in_ready_o;
    assign out_fire = out_valid_o & out_ready_i;

    // Occupancy and main entry. Flush overrides any handshake in the same cycle.
    always_comb begin
        occ_d  = occ_q;
        main_d = main_q;
        if (flush_i) begin
            occ_d  = OCC_EMPTY;
            main_d = '0;
        end else begin
            case (occ_q)
                OCC_EMPTY: begin
                    if (in_fire) begin
                        occ_d  = OCC_ONE;
                        main_d = in_data_i;
                    end
                end
                OCC_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data_i;
                    end else if (in_fire) begin
                        // only reachable with a skid entry; without one,
                        // in_ready_o implies out_ready_i while main is valid
                        occ_d = OCC_FULL;
                    end else if (out_fire) begin
                        occ_d = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (out_fire) begin
                        occ_d  = OCC_ONE;
                        main_d = skid_q;
                    end
                end
                default: occ_d = OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ_q  <= OCC_EMPTY;
            main_q <= '0;
        end else begin
            occ_q  <= occ_d;
            main_q <= main_d;
        end
    end

    generate
        if (SKID_EN != 0) begin : g_skid
            logic [DATA_W-1:0] skid_d;
            logic              rdy_d, rdy_q;

            // Skid only loads when main is busy and not draining this cycle.
            // in_ready_o is a flop, so it lags a downstream stall by one cycle.
            always_comb begin
                skid_d = skid_q;
                if (flush_i) begin
                    skid_d = '0;
                end else if (occ_q == OCC_ONE && in_fire && !out_fire) begin
                    skid_d = in_data_i;
                end
                rdy_d = (occ_d != OCC_FULL);
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    skid_q <= '0;
                    rdy_q  <= 1'b1;
                end else begin
                    skid_q <= skid_d;
                    rdy_q  <= rdy_d;
                end
            end

            assign in_ready_o = rdy_q;
        end else begin : g_noskid
            assign skid_q     = '0;
            assign in_ready_o = !out_valid_o || out_ready_i;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Two instances: index 0 with SKID_EN=1, index 1 with SKID_EN=0. A FIFO
// reference model (bounded queue of depth 2 / 1) runs alongside both and is
// compared against every cycle; directed tables and sequences cover streaming,
// stall/skid, flush, combinational ready and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic [1:0]         in_valid, out_ready, flush;
    logic [1:0][DW-1:0] in_data;

    logic          ir0, ir1, ov0, ov1;
    logic [DW-1:0] od0, od1;
    logic [1:0]    oc0, oc1;

    logic [1:0]         in_ready, out_valid;
    logic [1:0][DW-1:0] out_data;
    logic [1:0][1:0]    occ;
    assign in_ready  = {ir1, ir0};
    assign out_valid = {ov1, ov0};
    assign out_data  = {od1, od0};
    assign occ       = {oc1, oc0};

    pipe_stage_reg #(.DATA_W(DW), .SKID_EN(1)) u_skid (
        .clk(clk), .reset_n(reset_n), .flush_i(flush[0]),
        .in_valid_i(in_valid[0]), .in_ready_o(ir0), .in_data_i(in_data[0]),
        .out_valid_o(ov0), .out_ready_i(out_ready[0]), .out_data_o(od0),
        .occ_o(oc0)
    );

    pipe_stage_reg #(.DATA_W(DW), .SKID_EN(0)) u_noskid (
        .clk(clk), .reset_n(reset_n), .flush_i(flush[1]),
        .in_valid_i(in_valid[1]), .in_ready_o(ir1), .in_data_i(in_data[1]),
        .out_valid_o(ov1), .out_ready_i(out_ready[1]), .out_data_o(od1),
        .occ_o(oc1)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: bounded FIFO per instance -------------
    logic [DW-1:0] m_ent [2][2];
    int            m_cnt [2];
    logic [DW-1:0] m_last[2];

    function automatic logic m_ready(input int i);
        if (i == 0) return (m_cnt[0] < 2);
        return (m_cnt[1] == 0) || out_ready[1];
    endfunction

    function automatic logic [DW-1:0] m_data(input int i);
        return (m_cnt[i] > 0) ? m_ent[i][0] : m_last[i];
    endfunction

    initial begin
        logic inf, outf;
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_last[i] = '0;
        end
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                for (int i = 0; i < 2; i++) begin
                    m_cnt[i] = 0; m_last[i] = '0;
                end
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (flush[i]) begin
                        m_cnt[i] = 0; m_last[i] = '0;
                    end else begin
                        inf  = in_valid[i] && m_ready(i);
                        outf = (m_cnt[i] > 0) && out_ready[i];
                        if (outf) begin
                            m_last[i]  = m_ent[i][0];
                            m_ent[i][0] = m_ent[i][1];
                            m_cnt[i]--;
                        end
                        if (inf) begin
                            m_ent[i][m_cnt[i]] = in_data[i];
                            m_cnt[i]++;
                        end
                    end
                end
            end
        end
    end

    // ---------------- per-cycle scoreboard compare ---------------------------
    logic          pv[2], pr[2], pf[2];
    logic [DW-1:0] pd[2];

    initial begin
        for (int i = 0; i < 2; i++) pv[i] = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n && chk_en) begin
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("u%0d out_valid", i), 64'(out_valid[i]), 64'(m_cnt[i] > 0));
                    chk($sformatf("u%0d occ", i), 64'(occ[i]), 64'(m_cnt[i]));
                    chk($sformatf("u%0d in_ready", i), 64'(in_ready[i]), 64'(m_ready(i)));
                    chk($sformatf("u%0d out_data", i), 64'(out_data[i]), 64'(m_data(i)));
                    if (pv[i] && !pr[i] && !pf[i])
                        chk($sformatf("u%0d stall stable", i), 64'(out_data[i]), 64'(pd[i]));
                    pv[i] = out_valid[i];
                    pr[i] = out_ready[i];
                    pf[i] = flush[i];
                    pd[i] = out_data[i];
                end
            end else begin
                for (int i = 0; i < 2; i++) pv[i] = 1'b0;
            end
        end
    end

    // ---------------- directed table for the skid instance -------------------
    typedef struct packed {
        logic          iv;
        logic [DW-1:0] id;
        logic          ordy;
        logic          fl;
        logic          ev;
        logic [DW-1:0] ed;
        logic [1:0]    eo;
        logic          er;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic iv, logic [DW-1:0] id, logic ordy, logic fl,
                                logic ev, logic [DW-1:0] ed, logic [1:0] eo, logic er);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
        v.ev = ev; v.ed = ed; v.eo = eo; v.er = er;
        return v;
    endfunction

    int vbias, rbias;

    initial begin
        reset_n = 1'b0;
        in_valid = '0; in_data = '0; out_ready = '0; flush = '0;
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;

        // reset values, both modes
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst u%0d out_valid", i), 64'(out_valid[i]), 64'd0);
            chk($sformatf("rst u%0d occ", i), 64'(occ[i]), 64'd0);
            chk($sformatf("rst u%0d out_data", i), 64'(out_data[i]), 64'd0);
            chk($sformatf("rst u%0d in_ready", i), 64'(in_ready[i]), 64'd1);
        end
        @(posedge clk); #1;
        chk_en = 1;

        // streaming 1..8: each appears the cycle after acceptance, occ stays 1
        for (int k = 1; k <= 8; k++) tbl.push_back(mk(1, DW'(k), 1, 0, 1, DW'(k), 2'd1, 1));
        // drain: data holds last value
        tbl.push_back(mk(0, 0, 1, 0, 0, 32'h8, 2'd0, 1));
        // stall with skid: A into main, B into skid, D refused
        tbl.push_back(mk(1, 32'hA, 0, 0, 1, 32'hA, 2'd1, 1));
        tbl.push_back(mk(1, 32'hB, 0, 0, 1, 32'hA, 2'd2, 0));
        tbl.push_back(mk(1, 32'hD, 0, 0, 1, 32'hA, 2'd2, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 32'hB, 2'd1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 32'hB, 2'd0, 1));
        // flush while FULL with an offered payload C (and ready downstream)
        tbl.push_back(mk(1, 32'h1, 0, 0, 1, 32'h1, 2'd1, 1));
        tbl.push_back(mk(1, 32'h2, 0, 0, 1, 32'h1, 2'd2, 0));
        tbl.push_back(mk(1, 32'hC, 1, 1, 0, 32'h0, 2'd0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 32'h0, 2'd0, 1));

        foreach (tbl[j]) begin
            in_valid[0] = tbl[j].iv; in_data[0] = tbl[j].id;
            out_ready[0] = tbl[j].ordy; flush[0] = tbl[j].fl;
            @(posedge clk); #1;
            chk($sformatf("tbl%0d out_valid", j), 64'(out_valid[0]), 64'(tbl[j].ev));
            chk($sformatf("tbl%0d out_data", j), 64'(out_data[0]), 64'(tbl[j].ed));
            chk($sformatf("tbl%0d occ", j), 64'(occ[0]), 64'(tbl[j].eo));
            chk($sformatf("tbl%0d in_ready", j), 64'(in_ready[0]), 64'(tbl[j].er));
        end
        in_valid[0] = 0; out_ready[0] = 0; flush[0] = 0;

        // single-entry mode: ready follows out_ready combinationally
        in_valid[1] = 1; in_data[1] = 32'h55; out_ready[1] = 0;
        @(posedge clk); #1;
        in_valid[1] = 0;
        chk("nsk load valid", 64'(out_valid[1]), 64'd1);
        chk("nsk load data", 64'(out_data[1]), 64'h55);
        #1 chk("nsk rdy lo", 64'(in_ready[1]), 64'd0);
        out_ready[1] = 1;
        #1 chk("nsk rdy hi", 64'(in_ready[1]), 64'd1);
        out_ready[1] = 0;
        #1 chk("nsk rdy lo2", 64'(in_ready[1]), 64'd0);
        chk("nsk occ", 64'(occ[1]), 64'd1);
        @(posedge clk); #1;
        in_valid[1] = 1; in_data[1] = 32'h66; out_ready[1] = 1;
        @(posedge clk); #1;
        chk("nsk pass data", 64'(out_data[1]), 64'h66);
        chk("nsk pass occ", 64'(occ[1]), 64'd1);
        in_valid[1] = 0;
        @(posedge clk); #1;
        chk("nsk drain valid", 64'(out_valid[1]), 64'd0);
        chk("nsk drain data", 64'(out_data[1]), 64'h66);
        out_ready[1] = 0;

        // asynchronous reset while FULL
        chk_en = 0;
        in_valid[0] = 1; in_data[0] = 32'h11; out_ready[0] = 0;
        @(posedge clk); #1;
        in_data[0] = 32'h22;
        @(posedge clk); #1;
        in_valid[0] = 0;
        chk("pre-rst occ", 64'(occ[0]), 64'd2);
        #1 reset_n = 1'b0;
        #1;
        chk("arst out_valid", 64'(out_valid[0]), 64'd0);
        chk("arst occ", 64'(occ[0]), 64'd0);
        chk("arst out_data", 64'(out_data[0]), 64'd0);
        chk("arst in_ready", 64'(in_ready[0]), 64'd1);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk); #1;
        chk_en = 1;

        // random traffic and back-pressure, both modes
        vbias = 70; rbias = 50;
        for (int c = 0; c < 10000; c++) begin
            if (c % 500 == 0) begin
                vbias = int'($urandom_range(10, 100));
                rbias = int'($urandom_range(5, 100));
            end
            for (int i = 0; i < 2; i++) begin
                in_valid[i]  = ($urandom_range(0, 99) < vbias);
                in_data[i]   = $urandom;
                out_ready[i] = ($urandom_range(0, 99) < rbias);
                flush[i]     = ($urandom_range(0, 199) == 0);
            end
            @(posedge clk); #1;
        end
        in_valid = '0; out_ready = '0; flush = '0;
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
